// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parameterised synchronous FIFO; define FIFO_FWFT_EN for first-word-fall-through
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 256,
    parameter int AF_LEVEL = 254,
    parameter int AE_LEVEL = 2
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     data_count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);

    // Thresholds and constants sized to the count/pointer width
    localparam logic [AW:0] AF_C  = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C  = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] ONE_C = (AW+1)'(1);

    // Storage array; deliberately not reset
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              af_q, af_d;
    logic              ae_q, ae_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              wr_acc;
    logic              rd_acc;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;

    assign wr_acc  = wr_en & ~full_q;
    assign rd_acc  = rd_en & ~empty_q;
    assign wr_addr = wr_ptr_q[AW-1:0];
    assign rd_addr = rd_ptr_q[AW-1:0];

    // Next pointer, count and status flags computed from the post-edge pointers
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + ONE_C;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - ONE_C;
        end
        full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
        empty_d = (wr_ptr_d == rd_ptr_d);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
        ovf_d   = wr_en & full_q;
        unf_d   = rd_en & empty_q;
    end

`ifdef FIFO_FWFT_EN
    logic [AW-1:0] head_addr;
    logic          head_bypass;

    assign head_addr   = rd_ptr_d[AW-1:0];
    // The head slot is being written this edge only when the word lands in an otherwise drained FIFO
    assign head_bypass = wr_acc && (wr_addr == head_addr);

    // Output register tracks the post-edge head entry; holds while empty
    always_comb begin
        rd_data_d = rd_data_q;
        if (!empty_d) begin
            rd_data_d = head_bypass ? wr_data : mem[head_addr];
        end
    end
`else
    // Output register loads the read entry only on an accepted read
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_acc) begin
            rd_data_d = mem[rd_addr];
        end
    end
`endif

    // Array write on accepted writes only
    always_ff @(posedge sys_clk) begin
        if (wr_acc) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Control state with asynchronous clear
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign data_count   = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param (DEPTH=16)
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int DP = 16;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [4:0]    data_count;
    logic          overflow;
    logic          underflow;

    int vectors;
    int miscompares;

    sync_fifo_param #(
        .DATA_W  (DW),
        .DEPTH   (DP),
        .AF_LEVEL(14),
        .AE_LEVEL(2)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .data_count  (data_count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a plain queue of words plus the last registered pulses
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_rd;
    logic          m_ovf;
    logic          m_unf;
    int            m_sz;

    initial begin
        m_rd  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_rd  = '0;
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                m_sz  = m_q.size();
                m_ovf = wr_en && (m_sz == DP);
                m_unf = rd_en && (m_sz == 0);
                if (rd_en && m_sz > 0) begin
`ifndef FIFO_FWFT_EN
                    m_rd = m_q[0];
`endif
                    void'(m_q.pop_front());
                end
                if (wr_en && m_sz < DP) begin
                    m_q.push_back(wr_data);
                end
`ifdef FIFO_FWFT_EN
                if (m_q.size() > 0) begin
                    m_rd = m_q[0];
                end
`endif
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("m_count", 32'(data_count), 32'(m_q.size()));
            chk("m_full", 32'(full), 32'(m_q.size() == DP));
            chk("m_empty", 32'(empty), 32'(m_q.size() == 0));
            chk("m_af", 32'(almost_full), 32'(m_q.size() >= 14));
            chk("m_ae", 32'(almost_empty), 32'(m_q.size() <= 2));
            chk("m_ovf", 32'(overflow), 32'(m_ovf));
            chk("m_unf", 32'(underflow), 32'(m_unf));
`ifdef FIFO_FWFT_EN
            if (m_q.size() > 0) chk("m_rd_data", 32'(rd_data), 32'(m_rd));
`else
            chk("m_rd_data", 32'(rd_data), 32'(m_rd));
`endif
        end
    end

    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(data_count), 32'd0);
        chk("rst_ae", 32'(almost_empty), 32'd1);
        chk("rst_rd_data", 32'(rd_data), 32'd0);

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            chk("fill_af", 32'(almost_full), 32'(i >= 14));
            chk("fill_ae", 32'(almost_empty), 32'(i <= 2));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(data_count), 32'd16);

        // Write while full
        cyc(1'b1, 8'hAA, 1'b0);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(data_count), 32'd16);
        cyc(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Drain: 0x01..0x10, never 0xAA
        for (int i = 1; i <= 16; i++) begin
`ifdef FIFO_FWFT_EN
            chk("drain_head", 32'(rd_data), 32'(i));
            cyc(1'b0, 8'h00, 1'b1);
`else
            cyc(1'b0, 8'h00, 1'b1);
            chk("drain_data", 32'(rd_data), 32'(i));
`endif
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Read while empty
        cyc(1'b0, 8'h00, 1'b1);
        chk("unf_pulse", 32'(underflow), 32'd1);
        chk("unf_count", 32'(data_count), 32'd0);
`ifndef FIFO_FWFT_EN
        chk("unf_rd_hold", 32'(rd_data), 32'h10);
`endif
        cyc(1'b0, 8'h00, 1'b0);
        chk("unf_clear", 32'(underflow), 32'd0);

        // Fill 10, then 40 cycles of simultaneous write/read across the wrap
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 8'(8'h2A + k), 1'b1);
            chk("stream_count", 32'(data_count), 32'd10);
`ifdef FIFO_FWFT_EN
            chk("stream_data", 32'(rd_data), 32'(8'(8'h21 + k)));
`else
            chk("stream_data", 32'(rd_data), 32'(8'(8'h20 + k)));
`endif
        end
        for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);

        // Fill 8 then reset between edges
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
        chk("pre_rst_count", 32'(data_count), 32'd8);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_count", 32'(data_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 8'h55, 1'b0);
`ifdef FIFO_FWFT_EN
        chk("post_rst_fwft", 32'(rd_data), 32'h55);
`endif
        cyc(1'b0, 8'h00, 1'b1);
`ifndef FIFO_FWFT_EN
        chk("post_rst_read", 32'(rd_data), 32'h55);
`endif
        chk("post_rst_count", 32'(data_count), 32'd0);

        // Write into empty FIFO
        cyc(1'b1, 8'h3C, 1'b0);
        chk("w3c_empty", 32'(empty), 32'd0);
`ifdef FIFO_FWFT_EN
        chk("w3c_fwft", 32'(rd_data), 32'h3C);
`else
        chk("w3c_hold", 32'(rd_data), 32'h55);
`endif
        cyc(1'b0, 8'h00, 1'b1);

        // Simultaneous write/read when empty
        cyc(1'b1, 8'h77, 1'b1);
        chk("emp_both_unf", 32'(underflow), 32'd1);
        chk("emp_both_count", 32'(data_count), 32'd1);

        // Simultaneous write/read when full
        for (int i = 0; i < 15; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
        chk("full2", 32'(full), 32'd1);
        cyc(1'b1, 8'hEE, 1'b1);
        chk("full_both_ovf", 32'(overflow), 32'd1);
        chk("full_both_count", 32'(data_count), 32'd15);
`ifndef FIFO_FWFT_EN
        chk("full_both_data", 32'(rd_data), 32'h77);
`endif
        for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("final_empty", 32'(empty), 32'd1);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
